// File: rtl/lcd_draw_seq.sv
// lcd_draw_seq
// Arbitrates between NUMBTN button-drawing clients and sequences one
// rectangle fill at a time onto a 16-bit LCD word stream.
// For each granted client it sends the column/row window commands from the
// latched coordinates. It then streams that client's colour word once per
// accepted handshake until the client raises drawdone.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   en              : allows new grants (never aborts a running transaction)
//   update          : per-client redraw request, sampled only while idle
//   drawdone        : per-client "last pixel already taken" flag
//   xstart/xend/ystart/yend/color : 16 bits per client, client i at [16*i +: 16]
//   draw            : one-hot, high from ARM through the last STREAM cycle
//   cnext           : one-hot pixel-advance strobe, same cycle as the transfer
//   lcd_valid/lcd_ready : word handshake towards the LCD bus writer
//   lcd_dc          : 0 = command word, 1 = data word
//   lcd_data        : command code or data word
//   busy            : high whenever a transaction is in progress
//   cur             : index of the granted client (0 while idle)
module lcd_draw_seq #(
  parameter int NUMBTN  = 4,
  parameter int IDXBITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUMBTN-1:0]     update,
  input  logic [NUMBTN-1:0]     drawdone,
  input  logic [16*NUMBTN-1:0]  xstart,
  input  logic [16*NUMBTN-1:0]  xend,
  input  logic [16*NUMBTN-1:0]  ystart,
  input  logic [16*NUMBTN-1:0]  yend,
  input  logic [16*NUMBTN-1:0]  color,
  output logic [NUMBTN-1:0]     draw,
  output logic [NUMBTN-1:0]     cnext,
  output logic                  lcd_valid,
  input  logic                  lcd_ready,
  output logic                  lcd_dc,
  output logic [15:0]           lcd_data,
  output logic                  busy,
  output logic [IDXBITS-1:0]    cur
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ARM,
    S_STREAM,
    S_RELEASE
  } state_t;

  state_t               state_q, state_d;
  logic [IDXBITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDXBITS-1:0]   cur_q, cur_d;
  logic [2:0]           widx_q, widx_d;
  logic [15:0]          xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;

  logic                 gnt_found;
  logic [IDXBITS-1:0]   gnt_idx;
  logic [IDXBITS-1:0]   cand;
  logic [16:0]          cmd_w;

  // Command sequence word {dc, data} for position idx of the window setup.
  function automatic logic [16:0] cmd_word(input logic [2:0] idx,
                                           input logic [15:0] xs, input logic [15:0] xe,
                                           input logic [15:0] ys, input logic [15:0] ye);
    logic [16:0] w;
    case (idx)
      3'd0:    w = {1'b0, 16'h002A};
      3'd1:    w = {1'b1, xs};
      3'd2:    w = {1'b1, xe};
      3'd3:    w = {1'b0, 16'h002B};
      3'd4:    w = {1'b1, ys};
      3'd5:    w = {1'b1, ye};
      default: w = {1'b0, 16'h002C};
    endcase
    return w;
  endfunction

  // Round-robin search: first requesting client at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUMBTN; k++) begin
      cand = IDXBITS'((int'(rr_ptr_q) + k) % NUMBTN);
      if (!gnt_found && update[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign cmd_w = cmd_word(widx_q, xs_q, xe_q, ys_q, ye_q);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cur_d     = cur_q;
    widx_d    = widx_q;
    xs_d      = xs_q;
    xe_d      = xe_q;
    ys_d      = ys_q;
    ye_d      = ye_q;
    draw      = '0;
    cnext     = '0;
    lcd_valid = 1'b0;
    lcd_dc    = 1'b0;
    lcd_data  = '0;
    busy      = (state_q != S_IDLE);
    cur       = (state_q == S_IDLE) ? '0 : cur_q;

    case (state_q)
      S_IDLE: begin
        if (en && gnt_found) begin
          state_d = S_CMD;
          cur_d   = gnt_idx;
          widx_d  = '0;
          xs_d    = xstart[16*gnt_idx +: 16];
          xe_d    = xend[16*gnt_idx +: 16];
          ys_d    = ystart[16*gnt_idx +: 16];
          ye_d    = yend[16*gnt_idx +: 16];
        end
      end
      S_CMD: begin
        // Word is a pure function of registered state, so it holds while stalled.
        lcd_valid = 1'b1;
        lcd_dc    = cmd_w[16];
        lcd_data  = cmd_w[15:0];
        if (lcd_ready) begin
          if (widx_q == 3'd6) state_d = S_ARM;
          else                widx_d  = widx_q + 3'd1;
        end
      end
      S_ARM: begin
        // One quiet cycle so the client sees draw before drawdone is trusted.
        draw[cur_q] = 1'b1;
        state_d     = S_STREAM;
      end
      S_STREAM: begin
        draw[cur_q]  = 1'b1;
        lcd_dc       = 1'b1;
        lcd_data     = color[16*cur_q +: 16];
        lcd_valid    = !drawdone[cur_q];
        cnext[cur_q] = lcd_valid & lcd_ready;
        if (drawdone[cur_q]) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        rr_ptr_d = (cur_q == IDXBITS'(NUMBTN - 1)) ? '0 : cur_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: reset returns to idle and abandons any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      cur_q    <= '0;
      widx_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cur_q    <= cur_d;
      widx_q   <= widx_d;
    end
  end

  // Latched window coordinates: only read in CMD, always reloaded at grant.
  always_ff @(posedge clk) begin
    xs_q <= xs_d;
    xe_q <= xe_d;
    ys_q <= ys_d;
    ye_q <= ye_d;
  end

endmodule

// File: tb/tb_lcd_draw_seq.sv
module tb_lcd_draw_seq;
  localparam int NUMBTN  = 4;
  localparam int IDXBITS = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [NUMBTN-1:0]    update;
  logic [NUMBTN-1:0]    drawdone;
  logic [16*NUMBTN-1:0] xstart, xend, ystart, yend, color;
  logic [NUMBTN-1:0]    draw;
  logic [NUMBTN-1:0]    cnext;
  logic                 lcd_valid;
  logic                 lcd_ready;
  logic                 lcd_dc;
  logic [15:0]          lcd_data;
  logic                 busy;
  logic [IDXBITS-1:0]   cur;

  lcd_draw_seq #(.NUMBTN(NUMBTN), .IDXBITS(IDXBITS)) dut (
    .clk(clk), .rst(rst), .en(en), .update(update), .drawdone(drawdone),
    .xstart(xstart), .xend(xend), .ystart(ystart), .yend(yend), .color(color),
    .draw(draw), .cnext(cnext), .lcd_valid(lcd_valid), .lcd_ready(lcd_ready),
    .lcd_dc(lcd_dc), .lcd_data(lcd_data), .busy(busy), .cur(cur)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dc;
    logic [15:0] data;
    bit          pix;
    int          cl;
  } word_t;

  word_t sb[$];
  int    exp_cur[$];
  int    checks;
  int    errors;
  int    grants;
  int    pulses[NUMBTN];
  int    npix[NUMBTN];
  int    cnt[NUMBTN];
  bit    bp_mode;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Client model: counts accepted pixels, raises drawdone once npix were taken.
  always @(posedge clk) begin
    for (int i = 0; i < NUMBTN; i++) begin
      if (draw[i] !== 1'b1) cnt[i] <= 0;
      else if (cnext[i] === 1'b1) cnt[i] <= cnt[i] + 1;
    end
  end

  always_comb begin
    drawdone = '0;
    for (int i = 0; i < NUMBTN; i++)
      drawdone[i] = (draw[i] === 1'b1) && (cnt[i] >= npix[i]);
  end

  // lcd_ready driver: always ready, or the 1,0,0,1 stall pattern.
  initial begin
    int ph;
    logic [3:0] pat;
    ph = 0;
    pat = 4'b1001;
    lcd_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (bp_mode) begin
        lcd_ready = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        lcd_ready = 1'b1;
      end
    end
  end

  // Output monitor: compares every offered word against the scoreboard head.
  initial begin
    word_t h;
    bit busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        busy_prev = 1'b0;
        continue;
      end
      if (busy === 1'b1 && !busy_prev) begin
        grants++;
        if (exp_cur.size() == 0) check(32'(cur), 32'd99, "unexpected grant");
        else                     check(32'(cur), exp_cur.pop_front(), "grant cur");
      end
      busy_prev = (busy === 1'b1);
      for (int i = 0; i < NUMBTN; i++) if (cnext[i] === 1'b1) pulses[i]++;
      if (lcd_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check(32'(lcd_valid), 32'd0, "unexpected word");
        end else begin
          h = sb[0];
          check({lcd_dc, lcd_data}, {h.dc, h.data}, "word");
          check(draw, h.pix ? (32'd1 << h.cl) : 32'd0, "draw");
          check(cnext, (h.pix && lcd_ready) ? (32'd1 << h.cl) : 32'd0, "cnext");
          if (lcd_ready === 1'b1) void'(sb.pop_front());
        end
      end else begin
        check(cnext, 32'd0, "cnext idle");
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic push_txn(input int c);
    word_t w;
    w.pix = 1'b0; w.cl = c;
    w.dc = 1'b0; w.data = 16'h002A;             sb.push_back(w);
    w.dc = 1'b1; w.data = xstart[16*c +: 16];   sb.push_back(w);
    w.dc = 1'b1; w.data = xend[16*c +: 16];     sb.push_back(w);
    w.dc = 1'b0; w.data = 16'h002B;             sb.push_back(w);
    w.dc = 1'b1; w.data = ystart[16*c +: 16];   sb.push_back(w);
    w.dc = 1'b1; w.data = yend[16*c +: 16];     sb.push_back(w);
    w.dc = 1'b0; w.data = 16'h002C;             sb.push_back(w);
    w.pix = 1'b1; w.dc = 1'b1; w.data = color[16*c +: 16];
    for (int p = 0; p < npix[c]; p++) sb.push_back(w);
    exp_cur.push_back(c);
  endtask

  task automatic wait_busy(input logic val, input int budget, input string tag);
    int k;
    k = 0;
    while (busy !== val && k < budget) begin step(); k++; end
    check(32'(busy), 32'(val), tag);
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k;
    k = 0;
    while (grants < n && k < budget) begin step(); k++; end
    check(32'(grants), 32'(n), "grant count");
  endtask

  task automatic wait_pix(input int c, input int n, input int budget);
    int k;
    k = 0;
    while (pulses[c] < n && k < budget) begin step(); k++; end
    check(32'(pulses[c] >= n), 32'd1, "wait pixels");
  endtask

  task automatic wait_draw(input int c, input int budget);
    int k;
    k = 0;
    while (draw[c] !== 1'b1 && k < budget) begin step(); k++; end
    check(32'(draw[c]), 32'd1, "wait draw");
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < NUMBTN; i++) pulses[i] = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    checks = 0; errors = 0; grants = 0; bp_mode = 1'b0;
    rst = 1'b1; en = 1'b0; update = '0;
    for (int i = 0; i < NUMBTN; i++) begin pulses[i] = 0; cnt[i] = 0; end
    xstart = {16'h0090, 16'h0050, 16'h0030, 16'd10};
    xend   = {16'h0090, 16'h0060, 16'h003F, 16'd11};
    ystart = {16'h00A0, 16'h0070, 16'h0040, 16'd20};
    yend   = {16'h00A0, 16'h0071, 16'h004F, 16'd21};
    color  = {16'hFFFF, 16'h001F, 16'h07E0, 16'hF800};
    npix[0] = 4; npix[1] = 2; npix[2] = 3; npix[3] = 1;

    // Reset state
    step(); step(); step();
    check(32'(draw), 32'd0, "reset draw");
    check(32'(cnext), 32'd0, "reset cnext");
    check(32'(lcd_valid), 32'd0, "reset lcd_valid");
    check(32'(lcd_dc), 32'd0, "reset lcd_dc");
    check(32'(lcd_data), 32'd0, "reset lcd_data");
    check(32'(busy), 32'd0, "reset busy");
    check(32'(cur), 32'd0, "reset cur");
    rst = 1'b0; en = 1'b1;

    // Single request, client 0, four pixels
    clear_pulses();
    push_txn(0);
    update = 4'b0001;
    wait_busy(1'b1, 20, "single grant");
    update = 4'b0000;
    wait_busy(1'b0, 100, "single done");
    check(32'(pulses[0]), 32'd4, "single cnext pulses");
    check(32'(sb.size()), 32'd0, "single sb empty");

    // Round-robin from pointer 0 with all requests held
    rst = 1'b1; step(); rst = 1'b0;
    clear_pulses();
    g0 = grants;
    push_txn(0); push_txn(1); push_txn(2); push_txn(3); push_txn(0);
    update = 4'b1111;
    wait_grants(g0 + 5, 400);
    update = 4'b0000;
    wait_busy(1'b0, 100, "rr done");
    check(32'(sb.size()), 32'd0, "rr sb empty");
    check(32'(pulses[0]), 32'd8, "rr pulses 0");
    check(32'(pulses[3]), 32'd1, "rr pulses 3");

    // Grant 2, then 0 and 3 pending: 3 comes before 0
    g0 = grants;
    push_txn(2); push_txn(3); push_txn(0);
    update = 4'b0100;
    wait_grants(g0 + 1, 50);
    update = 4'b1001;
    wait_grants(g0 + 3, 200);
    update = 4'b0000;
    wait_busy(1'b0, 100, "rr2 done");
    check(32'(sb.size()), 32'd0, "rr2 sb empty");

    // Backpressure with ready pattern 1,0,0,1
    bp_mode = 1'b1;
    clear_pulses();
    push_txn(0);
    update = 4'b0001;
    wait_busy(1'b1, 20, "bp grant");
    update = 4'b0000;
    wait_busy(1'b0, 200, "bp done");
    check(32'(pulses[0]), 32'd4, "bp cnext pulses");
    check(32'(sb.size()), 32'd0, "bp sb empty");
    bp_mode = 1'b0;

    // en low blocks grants; en dropped during STREAM does not abort
    en = 1'b0;
    update = 4'b0010;
    g0 = grants;
    for (int i = 0; i < 10; i++) begin
      step();
      check(32'(busy), 32'd0, "en0 busy");
    end
    check(32'(grants), 32'(g0), "en0 no grant");
    clear_pulses();
    npix[1] = 6;
    push_txn(1);
    en = 1'b1;
    wait_busy(1'b1, 20, "en grant");
    update = 4'b0000;
    wait_draw(1, 50);
    en = 1'b0;
    wait_busy(1'b0, 100, "en drop done");
    check(32'(pulses[1]), 32'd6, "en drop pulses");
    check(32'(sb.size()), 32'd0, "en drop sb empty");
    en = 1'b1;

    // Reset in STREAM after two pixels, then regrant from the first command
    clear_pulses();
    npix[2] = 8;
    push_txn(2);
    update = 4'b0100;
    wait_pix(2, 2, 100);
    rst = 1'b1;
    sb.delete();
    exp_cur.delete();
    step();
    check(32'(draw), 32'd0, "rst draw");
    check(32'(lcd_valid), 32'd0, "rst lcd_valid");
    check(32'(busy), 32'd0, "rst busy");
    check(32'(cur), 32'd0, "rst cur");
    check(32'(cnext), 32'd0, "rst cnext");
    rst = 1'b0;
    clear_pulses();
    push_txn(2);
    wait_busy(1'b1, 20, "regrant");
    update = 4'b0000;
    wait_busy(1'b0, 100, "regrant done");
    check(32'(pulses[2]), 32'd8, "regrant pulses");
    check(32'(sb.size()), 32'd0, "regrant sb empty");

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
